iob_sum8_master: RTL and testbench
==================================

Name: iob_sum8_master

Overview:
IOb native initiator that streams LEN consecutive 256-bit words from memory through the IOb cache/memory_wrapper slave port. It sums the eight 32-bit lanes of every word into one 32-bit accumulator and writes the result back to a destination word. This is the master-side counterpart of the memory_wrapper front-end, and the compute core of the 8-int-sum accelerator.

Parameters:
ADDR_W, 19, IOb word address width (one address = one 256-bit word)
DATA_W, 256, IOb data width; fixed at 8 lanes x 32 bits
LEN_W, 16, width of the word-count input

Ports:
clk_i  in  1  clock, rising edge
arst_n_i  in  1  asynchronous active-low reset
start_i  in  1  one-cycle start pulse, sampled in IDLE only
src_addr_i  in  ADDR_W  first source word address, latched on start
dst_addr_i  in  ADDR_W  result word address, latched on start
len_i  in  LEN_W  number of source words, latched on start
busy_o  out  1  high from the cycle after start until done_o
done_o  out  1  one-cycle pulse, result written
result_o  out  32  final sum, held until next start
ovf_o  out  1  sticky saturation flag (macro only, else 0)
iob_valid_o  out  1  request valid
iob_addr_o  out  ADDR_W  request word address
iob_wdata_o  out  DATA_W  write data
iob_wstrb_o  out  DATA_W/8  byte strobes; 0 = read
iob_rdata_i  in  DATA_W  read data
iob_rvalid_i  in  1  read data valid
iob_ready_i  in  1  request accepted

Behaviour:
- Reset (async, arst_n_i=0): state IDLE; outputs busy_o, done_o, iob_valid_o and ovf_o are 0; result_o is 0; iob_addr_o, iob_wdata_o and iob_wstrb_o are 0; internal counters are cleared.
- Reset mid-transaction: iob_valid_o drops immediately with no cycle delay, and any pending rvalid after reset is ignored.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE: when start_i=1, latch src, dst and len, clear the accumulator and go to RD_REQ. If len=0, go to WR_REQ instead. start_i is ignored in all other states.
- Request rule: iob_valid_o rises in the cycle after start. Address, wdata and wstrb stay stable while valid=1. A request is accepted at a posedge where valid=1 and iob_ready_i=1, and valid drops in the following cycle unless a new request issues.
- Outstanding requests: at most one at any time.
- RD_REQ: drive addr = src + idx with wstrb=0. On accept, go to RD_WAIT.
- RD_WAIT: iob_valid_o=0. On iob_rvalid_i=1, acc <= acc + sum of the 8 lanes (lane k = rdata[32k+31:32k]) and idx increments.
  - If idx+1 == len, go to WR_REQ; otherwise go to RD_REQ. The next read's valid is high in the following cycle.
  - rvalid received in any other state is ignored.
- Arithmetic: lanes are signed 32-bit; the per-word lane sum is formed at 35 bits.
  - Without the macro, the accumulator wraps modulo 2^32.
- Address arithmetic: src+idx wraps modulo 2^ADDR_W.
- WR_REQ: addr = dst, wdata = {224'b0, acc}, wstrb = 32'h0000000F. On accept, go to DONE. No rvalid is expected for writes.
- DONE: for one cycle, done_o=1, result_o=acc and busy_o=0 in that same cycle; then go to IDLE.
- Latency with ready always 1 and a fixed 1-cycle read return: 2*len + 3 cycles from start to done.
- Simultaneous events: start_i asserted in the DONE cycle is ignored; it is accepted only from the next cycle.

Optional Feature:
IOB_SUM8_SAT_EN:
- Defined: each accumulation saturates to the signed 32-bit range [32'h80000000, 32'h7FFFFFFF]. ovf_o is set when any clamp occurs and cleared on start.
- Undefined: the accumulator wraps modulo 2^32, ovf_o is tied 0 and no saturation logic is built.

Test Plan:
- Single word: word at 5 holds lanes 1..8, len=1, src=5, dst=20, ready=1 -> read addr 5, then write addr 20 with wdata low lane 36 and wstrb 0000000F. result_o=36, done 5 cycles after start.
- Multi-word: len=3 at src 5 with lanes all 1, all 2 and all 3 -> reads addr 5, 6 and 7 in order, one outstanding at a time. result_o=48.
- Backpressure: ready low for 4 cycles on every request -> addr and wdata stay stable while valid holds, and result is unchanged. Also drive a stray rvalid in RD_REQ -> it is ignored.
- Boundaries: len=0 -> no reads, write of 0 to dst, done. Also src=7FFFF with len=2 -> reads addr 7FFFF, then 00000.
- Overflow: 2 words with lanes all 32'h10000000 -> without the macro result 0; with IOB_SUM8_SAT_EN result 7FFFFFFF and ovf_o=1. Also negative lanes all 32'hF0000000 x2 words -> saturates to 80000000.
- Reset and start collision: assert arst_n_i=0 in RD_WAIT -> valid and busy drop immediately, and a restart completes correctly. Also start_i asserted while busy -> ignored, and the latched len is unchanged.

Source files
------------

// File: rtl/iob_sum8_master.sv
// iob_sum8_master: IOb initiator; reads len 256-bit words, sums every 32-bit lane, writes the sum to dst.
// Latency: 2*len+3 cycles start-to-done (ready=1, 1-cycle read return); never more than one request in flight.
// Backpressure: a request holds addr/wdata/wstrb until iob_ready_i; `IOB_SUM8_SAT_EN selects saturating accumulation.
module iob_sum8_master #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 256,
  parameter int LEN_W  = 16
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   src_addr_i,
  input  logic [ADDR_W-1:0]   dst_addr_i,
  input  logic [LEN_W-1:0]    len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [31:0]         result_o,
  output logic                ovf_o,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  input  logic                iob_rvalid_i,
  input  logic                iob_ready_i
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  src_q, src_d;
  logic [ADDR_W-1:0]  dst_q, dst_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W:0]     idx_inc;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        acc_next;
  logic [31:0]        result_q, result_d;

`ifdef IOB_SUM8_SAT_EN
  logic               ovf_q, ovf_d;
  logic               ovf_next;
  logic [34:0]        lane_sum;
  logic [35:0]        acc_wide;
`else
  // A wrapping accumulator only needs the low 32 bits of the lane sum.
  logic [31:0]        lane_sum;
`endif

  // Sum the eight signed lanes of the returning word and fold them into the accumulator
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < 8; k++) begin
`ifdef IOB_SUM8_SAT_EN
      lane_sum = lane_sum + {{3{iob_rdata_i[32*k+31]}}, iob_rdata_i[32*k +: 32]};
`else
      lane_sum = lane_sum + iob_rdata_i[32*k +: 32];
`endif
    end
`ifdef IOB_SUM8_SAT_EN
    // 36 bits hold any acc + word sum; bits [35:31] all equal means it fits in int32.
    acc_wide = {{4{acc_q[31]}}, acc_q} + {lane_sum[34], lane_sum};
    ovf_next = 1'b1;
    if (!acc_wide[35] && (|acc_wide[34:31])) begin
      acc_next = 32'h7FFF_FFFF;
    end else if (acc_wide[35] && !(&acc_wide[34:31])) begin
      acc_next = 32'h8000_0000;
    end else begin
      acc_next = acc_wide[31:0];
      ovf_next = 1'b0;
    end
`else
    acc_next = acc_q + lane_sum;
`endif
  end

  // Next-state, datapath updates and IOb request outputs
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    result_d    = result_q;
`ifdef IOB_SUM8_SAT_EN
    ovf_d       = ovf_q;
`endif
    idx_inc     = {1'b0, idx_q} + {{LEN_W{1'b0}}, 1'b1};
    busy_o      = 1'b0;
    done_o      = 1'b0;
    iob_valid_o = 1'b0;
    iob_addr_o  = '0;
    iob_wdata_o = '0;
    iob_wstrb_o = '0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          src_d   = src_addr_i;
          dst_d   = dst_addr_i;
          len_d   = len_i;
          idx_d   = '0;
          acc_d   = '0;
`ifdef IOB_SUM8_SAT_EN
          ovf_d   = 1'b0;
`endif
          state_d = (len_i == '0) ? WR_REQ : RD_REQ;
        end
      end
      RD_REQ: begin
        busy_o      = 1'b1;
        iob_valid_o = 1'b1;
        iob_addr_o  = src_q + ADDR_W'(idx_q);
        if (iob_ready_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        busy_o = 1'b1;
        if (iob_rvalid_i) begin
          acc_d = acc_next;
`ifdef IOB_SUM8_SAT_EN
          if (ovf_next) ovf_d = 1'b1;
`endif
          idx_d   = idx_inc[LEN_W-1:0];
          state_d = (idx_inc == {1'b0, len_q}) ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        busy_o      = 1'b1;
        iob_valid_o = 1'b1;
        iob_addr_o  = dst_q;
        iob_wdata_o = {{(DATA_W-32){1'b0}}, acc_q};
        iob_wstrb_o = {{(STRB_W-4){1'b0}}, 4'hF};
        if (iob_ready_i) begin
          result_d = acc_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset returns everything to idle and zero
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
`ifdef IOB_SUM8_SAT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
`ifdef IOB_SUM8_SAT_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign result_o = result_q;
`ifdef IOB_SUM8_SAT_EN
  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_iob_sum8_master.sv
// tb_iob_sum8_master: drives sum jobs against a behavioural memory slave and a lane-sum reference model.
// Latency: checks 2*len+3 start-to-done when the slave never stalls.
// Backpressure: slave can stall each request and inject stray read data while stalled.
module tb_iob_sum8_master;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 256;
  localparam int LEN_W  = 16;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic                clk = 1'b0;
  logic                arst_n_i;
  logic                start_i;
  logic [ADDR_W-1:0]   src_addr_i, dst_addr_i;
  logic [LEN_W-1:0]    len_i;
  logic                busy_o, done_o, ovf_o, iob_valid_o;
  logic [31:0]         result_o;
  logic [ADDR_W-1:0]   iob_addr_o;
  logic [DATA_W-1:0]   iob_wdata_o, iob_rdata_i;
  logic [DATA_W/8-1:0] iob_wstrb_o;
  logic                iob_rvalid_i, iob_ready_i;

  iob_sum8_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .arst_n_i(arst_n_i), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .ovf_o(ovf_o),
    .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
    .iob_wstrb_o(iob_wstrb_o), .iob_rdata_i(iob_rdata_i), .iob_rvalid_i(iob_rvalid_i),
    .iob_ready_i(iob_ready_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sparse word memory seen by the slave and by the reference model.
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  // Reference: signed lane sum per word, then wrap or clamp the running total.
  task automatic model(input logic [ADDR_W-1:0] src, input int len,
                       output logic [31:0] res, output bit ovf);
    longint acc = 0;
    longint ws;
    logic [DATA_W-1:0] w;
    ovf = 1'b0;
    for (int i = 0; i < len; i++) begin
      w  = mem_rd(src + ADDR_W'(i));
      ws = 0;
      for (int k = 0; k < 8; k++) ws += longint'($signed(w[32*k +: 32]));
      acc += ws;
`ifdef IOB_SUM8_SAT_EN
      if (acc > SMAX) begin acc = SMAX; ovf = 1'b1; end
      else if (acc < SMIN) begin acc = SMIN; ovf = 1'b1; end
`else
      acc = longint'(int'(acc));
`endif
    end
    res = acc[31:0];
  endtask

  // Behavioural IOb slave: optional stall per request, read data one cycle after accept.
  typedef struct {
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
  } req_t;

  req_t              log_q[$];
  req_t              hold;
  int                bp_cycles = 0;
  bit                stray_en  = 1'b0;
  int                stall_cnt = 0;
  bit                rd_pend   = 1'b0;
  logic [ADDR_W-1:0] pend_addr;

  always @(negedge clk) begin
    iob_rvalid_i = 1'b0;
    if (rd_pend) begin
      check_eq("one_outstanding", iob_valid_o, 1'b0);
      iob_rvalid_i = 1'b1;
      iob_rdata_i  = mem_rd(pend_addr);
      rd_pend      = 1'b0;
    end
    if (iob_valid_o) begin
      if (stall_cnt > 0) begin
        check_eq("stable_addr", iob_addr_o, hold.addr);
        check_eq("stable_wdata", iob_wdata_o, hold.wdata);
        check_eq("stable_wstrb", iob_wstrb_o, hold.wstrb);
      end else begin
        hold = '{iob_addr_o, iob_wdata_o, iob_wstrb_o};
      end
      if (stall_cnt < bp_cycles) begin
        iob_ready_i = 1'b0;
        stall_cnt++;
        if (stray_en && iob_wstrb_o == '0) begin
          iob_rvalid_i = 1'b1;
          iob_rdata_i  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        end
      end else begin
        iob_ready_i = 1'b1;
        stall_cnt   = 0;
        log_q.push_back(hold);
        if (iob_wstrb_o == '0) begin
          rd_pend   = 1'b1;
          pend_addr = iob_addr_o;
        end
      end
    end else begin
      iob_ready_i = 1'b0;
      stall_cnt   = 0;
    end
  end

  task automatic run_job(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst, input int len,
                         input int bp, input bit stray, input bit lat_chk, input bit collide,
                         input bit done_start);
    logic [31:0]       exp_res;
    bit                exp_ovf;
    int                cyc;
    int                limit;
    int                nrd;
    logic [ADDR_W-1:0] a;
    model(src, len, exp_res, exp_ovf);
    log_q.delete();
    bp_cycles = bp;
    stray_en  = stray;
    @(negedge clk);
    start_i    = 1'b1;
    src_addr_i = src;
    dst_addr_i = dst;
    len_i      = LEN_W'(len);
    @(posedge clk); #1;
    start_i = 1'b0;
    check_eq("busy_after_start", busy_o, 1'b1);
    cyc   = 0;
    limit = 50 + len * (2 * bp + 6);
    while (!done_o && cyc < limit) begin
      if (collide && cyc == 1) begin
        start_i    = 1'b1;
        len_i      = LEN_W'(7);
        src_addr_i = src + ADDR_W'(100);
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    if (cyc >= limit) begin
      check_eq("done_timeout", 1'b0, 1'b1);
      return;
    end
    check_eq("result", result_o, exp_res);
    check_eq("busy_in_done", busy_o, 1'b0);
    check_eq("ovf", ovf_o, exp_ovf);
    // cyc counts edges after the start edge; inclusive of start and done cycles that is cyc+2.
    if (lat_chk) check_eq("latency", cyc + 2, 2 * len + 3);
    nrd = 0;
    foreach (log_q[i]) if (log_q[i].wstrb == '0) nrd++;
    check_eq("n_reads", nrd, len);
    check_eq("n_reqs", log_q.size(), len + 1);
    if (log_q.size() == len + 1) begin
      for (int i = 0; i < len; i++) begin
        a = src + ADDR_W'(i);
        check_eq($sformatf("rd_addr%0d", i), log_q[i].addr, a);
      end
      check_eq("wr_addr", log_q[len].addr, dst);
      check_eq("wr_wdata", log_q[len].wdata, {224'b0, exp_res});
      check_eq("wr_wstrb", log_q[len].wstrb, 32'h0000_000F);
    end
    if (done_start) begin
      start_i = 1'b1;
      len_i   = LEN_W'(2);
      @(posedge clk); #1;
      start_i = 1'b0;
      check_eq("start_in_done_ignored", busy_o, 1'b0);
      @(posedge clk); #1;
      check_eq("still_idle", busy_o, 1'b0);
      check_eq("result_held", result_o, exp_res);
    end else begin
      @(posedge clk); #1;
      check_eq("done_one_cycle", done_o, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] w;
    int t;
    int rl;
    logic [ADDR_W-1:0] rs;
    arst_n_i     = 1'b0;
    start_i      = 1'b0;
    src_addr_i   = '0;
    dst_addr_i   = '0;
    len_i        = '0;
    iob_rdata_i  = '0;
    iob_rvalid_i = 1'b0;
    iob_ready_i  = 1'b0;
    #3;
    check_eq("rst_valid", iob_valid_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_done", done_o, 1'b0);
    check_eq("rst_result", result_o, 32'h0);
    check_eq("rst_ovf", ovf_o, 1'b0);
    check_eq("rst_addr", iob_addr_o, '0);
    check_eq("rst_wdata", iob_wdata_o, '0);
    check_eq("rst_wstrb", iob_wstrb_o, '0);
    #9 arst_n_i = 1'b1;

    // Single word, lanes 1..8.
    w = '0;
    for (int k = 0; k < 8; k++) w[32*k +: 32] = 32'(k + 1);
    mem[19'd5] = w;
    run_job(19'd5, 19'd20, 1, 0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Three words of all-1, all-2, all-3; then the same under stalls with stray rvalid.
    mem[19'd5] = {8{32'd1}};
    mem[19'd6] = {8{32'd2}};
    mem[19'd7] = {8{32'd3}};
    run_job(19'd5, 19'd21, 3, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_job(19'd5, 19'd22, 3, 4, 1'b1, 1'b0, 1'b0, 1'b0);

    // Zero length, and address wrap at the top of the space.
    run_job(19'd9, 19'd23, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    mem[19'h7FFFF] = {8{32'h0000_0101}};
    mem[19'h00000] = {8{32'hFFFF_FFFE}};
    run_job(19'h7FFFF, 19'd24, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Positive and negative overflow.
    mem[19'd30] = {8{32'h1000_0000}};
    mem[19'd31] = {8{32'h1000_0000}};
    run_job(19'd30, 19'd25, 2, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    mem[19'd32] = {8{32'hF000_0000}};
    mem[19'd33] = {8{32'hF000_0000}};
    run_job(19'd32, 19'd26, 2, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_job(19'd5, 19'd27, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset while waiting for read data; the in-flight rvalid lands after release.
    mem[19'd40] = {8{32'd4}};
    mem[19'd41] = {8{32'd5}};
    mem[19'd42] = {8{32'd6}};
    bp_cycles = 0;
    stray_en  = 1'b0;
    @(negedge clk);
    start_i    = 1'b1;
    src_addr_i = 19'd40;
    dst_addr_i = 19'd50;
    len_i      = LEN_W'(3);
    @(posedge clk); #1;
    start_i = 1'b0;
    t = 0;
    while (!(busy_o && !iob_valid_o) && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("reach_rd_wait", t < 20, 1'b1);
    arst_n_i = 1'b0;
    #1;
    check_eq("midrst_valid", iob_valid_o, 1'b0);
    check_eq("midrst_busy", busy_o, 1'b0);
    #1 arst_n_i = 1'b1;
    for (int i = 0; i < 3; i++) @(posedge clk);
    #1;
    check_eq("post_rst_busy", busy_o, 1'b0);
    check_eq("post_rst_result", result_o, 32'h0);
    run_job(19'd40, 19'd50, 3, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Start pulse while busy must not disturb the running job.
    run_job(19'd40, 19'd51, 3, 0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Random jobs.
    for (int j = 0; j < 6; j++) begin
      rl = $urandom_range(1, 6);
      rs = ADDR_W'($urandom);
      for (int i = 0; i < rl; i++)
        mem[rs + ADDR_W'(i)] = {$urandom, $urandom, $urandom, $urandom,
                                $urandom, $urandom, $urandom, $urandom};
      run_job(rs, ADDR_W'($urandom), rl, $urandom_range(0, 2), 1'b1, 1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
